// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and key-state decoder.
// Receives scancode-set-2 bytes from a PS/2 keyboard. It keeps a held level for
// W/A/D and for the extended Up/Left/Right keys.
// Optional build macro: PS2_PARITY_CHECK_EN. When it is defined, frames that
// fail the odd-parity check are dropped.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_w,
    output logic       key_a,
    output logic       key_d,
    output logic       key_up,
    output logic       key_left,
    output logic       key_right,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit CHECK_PARITY = 1'b1;
`else
    localparam bit CHECK_PARITY = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    typedef struct packed {
        logic w;
        logic a;
        logic d;
        logic up;
        logic left;
        logic right;
    } keys_t;

    // Synchronizer and edge-detect flops. They reset to 1 because the bus idles high.
    logic [1:0] ps2_clk_sync_q;
    logic [1:0] ps2_data_sync_q;
    logic       ps2_clk_prev_q;
    logic       ps2_fall;
    logic       bit_in;

    // Receiver state
    rx_state_t    state_q;
    logic [2:0]   bit_cnt_q;
    logic [7:0]   shift_q;
    logic         parity_bit_q;
    logic [TW-1:0] tmo_cnt_q;
    logic         frame_done_q;
    logic         parity_ok;

    // Decoder state
    keys_t      keys_q, keys_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] rx_byte_q;
    logic       rx_valid_q;

    // Bring both PS/2 lines into the clk domain and keep one history bit of ps2_clk.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_sync_q  <= 2'b11;
            ps2_data_sync_q <= 2'b11;
            ps2_clk_prev_q  <= 1'b1;
        end else begin
            ps2_clk_sync_q  <= {ps2_clk_sync_q[0], ps2_clk};
            ps2_data_sync_q <= {ps2_data_sync_q[0], ps2_data};
            ps2_clk_prev_q  <= ps2_clk_sync_q[1];
        end
    end

    assign ps2_fall  = ps2_clk_prev_q & ~ps2_clk_sync_q[1];
    assign bit_in    = ps2_data_sync_q[1];
    // Odd parity: data bits plus the parity bit must contain an odd number of ones.
    assign parity_ok = ^{shift_q, parity_bit_q};

    // Frame receiver FSM. It samples on each falling edge and abandons stalled frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_bit_q <= 1'b0;
            tmo_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (state_q == IDLE || ps2_fall) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != TMO_MAX) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            if (state_q != IDLE && !ps2_fall && tmo_cnt_q == TMO_MAX) begin
                state_q   <= IDLE;
                bit_cnt_q <= 3'd0;
            end else if (ps2_fall) begin
                case (state_q)
                    IDLE: begin
                        if (!bit_in) begin
                            state_q   <= DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {bit_in, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit_q <= bit_in;
                        state_q      <= STOP;
                    end
                    STOP: begin
                        state_q      <= IDLE;
                        frame_done_q <= bit_in & (parity_ok | ~CHECK_PARITY);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Decode the accepted byte into the E0/F0 prefix flags and the key levels.
    // NOTE: every always_comb output gets a default first so that no latch is inferred.
    always_comb begin
        keys_d = keys_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        if (frame_done_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                case ({ext_q, shift_q})
                    9'h01D:  keys_d.w     = ~brk_q;
                    9'h01C:  keys_d.a     = ~brk_q;
                    9'h023:  keys_d.d     = ~brk_q;
                    9'h175:  keys_d.up    = ~brk_q;
                    9'h16B:  keys_d.left  = ~brk_q;
                    9'h174:  keys_d.right = ~brk_q;
                    default: keys_d       = keys_q;
                endcase
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // Register the decoder state, the rx_valid strobe and the last accepted byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            keys_q     <= keys_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            rx_valid_q <= frame_done_q;
            if (frame_done_q) begin
                rx_byte_q <= shift_q;
            end
        end
    end

    assign key_w     = keys_q.w;
    assign key_a     = keys_q.a;
    assign key_d     = keys_q.d;
    assign key_up    = keys_q.up;
    assign key_left  = keys_q.left;
    assign key_right = keys_q.right;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;

endmodule
